// File: rtl/fn_sweep_ctrl.sv
// Truth-table sweeper: drives all 16 {a,b,c,d} vectors, samples y and compares against EXPECTED.
// Define SWEEP_GRAY_EN to sweep in Gray-code order (one input toggles per step).
module fn_sweep_ctrl #(
   parameter int          SETTLE   = 1,
   parameter logic [15:0] EXPECTED = 16'hB921
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        dut_a,
   output logic        dut_b,
   output logic        dut_c,
   output logic        dut_d,
   input  logic        dut_y,
   output logic        busy,
   output logic        done,
   output logic [15:0] tt,
   output logic        mismatch,
   output logic [4:0]  err_cnt,
   output logic [3:0]  err_idx
);

   // state  | meaning
   // IDLE   | waiting for start; results from the last sweep held
   // DRIVE  | vector driven, settle counter running down
   // SAMPLE | capture dut_y and compare, then advance or finish
   // DONE   | one-cycle done pulse, last vector still held
   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

   localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

   state_t      state, state_nxt;
   logic [3:0]  seq, seq_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic [3:0]  vec_q, vec_nxt;
   logic        busy_nxt, done_nxt, mismatch_nxt;
   logic [15:0] tt_nxt;
   logic [4:0]  err_cnt_nxt;
   logic [3:0]  err_idx_nxt;

   function automatic logic [3:0] seq2vec(input logic [3:0] s);
`ifdef SWEEP_GRAY_EN
      return s ^ (s >> 1);
`else
      return s;
`endif
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         seq      <= '0;
         cnt      <= '0;
         vec_q    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         tt       <= '0;
         mismatch <= 1'b0;
         err_cnt  <= '0;
         err_idx  <= '0;
      end else begin
         state    <= state_nxt;
         seq      <= seq_nxt;
         cnt      <= cnt_nxt;
         vec_q    <= vec_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
         tt       <= tt_nxt;
         mismatch <= mismatch_nxt;
         err_cnt  <= err_cnt_nxt;
         err_idx  <= err_idx_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      seq_nxt      = seq;
      cnt_nxt      = cnt;
      vec_nxt      = vec_q;
      busy_nxt     = busy;
      done_nxt     = 1'b0;
      tt_nxt       = tt;
      mismatch_nxt = mismatch;
      err_cnt_nxt  = err_cnt;
      err_idx_nxt  = err_idx;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt    = DRIVE;
               seq_nxt      = '0;
               cnt_nxt      = SETTLE_LD;
               vec_nxt      = seq2vec(4'd0);
               busy_nxt     = 1'b1;
               tt_nxt       = '0;
               mismatch_nxt = 1'b0;
               err_cnt_nxt  = '0;
               err_idx_nxt  = '0;
            end
         end
         DRIVE: begin
            if (cnt == 4'd0) state_nxt = SAMPLE;
            else             cnt_nxt   = cnt - 4'd1;
         end
         SAMPLE: begin
            tt_nxt[vec_q] = dut_y;
            if (dut_y != EXPECTED[vec_q]) begin
               err_cnt_nxt  = err_cnt + 5'd1;
               mismatch_nxt = 1'b1;
               // mismatch still clear means this is the first failing vector
               if (!mismatch) err_idx_nxt = vec_q;
            end
            if (seq == 4'd15) begin
               state_nxt = DONE;
               done_nxt  = 1'b1;
               busy_nxt  = 1'b0;
            end else begin
               state_nxt = DRIVE;
               seq_nxt   = seq + 4'd1;
               vec_nxt   = seq2vec(seq + 4'd1);
               cnt_nxt   = SETTLE_LD;
            end
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign dut_a = vec_q[3];
   assign dut_b = vec_q[2];
   assign dut_c = vec_q[1];
   assign dut_d = vec_q[0];

endmodule

// File: tb/tb_fn_sweep_ctrl.sv
// Bench for fn_sweep_ctrl: a table-driven function model feeds dut_y; results are checked
// against counts derived from the response table and EXPECTED. Define SWEEP_GRAY_EN for Gray mode.
module tb_fn_sweep_ctrl;

`ifdef SWEEP_GRAY_EN
   localparam int SETTLE = 3;
   localparam bit GRAY   = 1'b1;
`else
   localparam int SETTLE = 1;
   localparam bit GRAY   = 1'b0;
`endif
   localparam logic [15:0] EXPECTED = 16'hB921;
   localparam int SWEEP_CYC = 16 * (SETTLE + 1);

   logic        clk = 1'b0;
   logic        rst, start;
   logic        dut_a, dut_b, dut_c, dut_d, dut_y;
   logic        busy, done, mismatch;
   logic [15:0] tt;
   logic [4:0]  err_cnt;
   logic [3:0]  err_idx;
   logic [15:0] fn_tt;
   logic [3:0]  vec;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   assign vec   = {dut_a, dut_b, dut_c, dut_d};
   assign dut_y = fn_tt[vec];

   fn_sweep_ctrl #(.SETTLE(SETTLE), .EXPECTED(EXPECTED)) u_dut (
      .clk(clk), .rst(rst), .start(start),
      .dut_a(dut_a), .dut_b(dut_b), .dut_c(dut_c), .dut_d(dut_d), .dut_y(dut_y),
      .busy(busy), .done(done), .tt(tt), .mismatch(mismatch),
      .err_cnt(err_cnt), .err_idx(err_idx)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] sweep_vec(input int i);
      return GRAY ? 4'(i ^ (i >> 1)) : 4'(i);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start a sweep (start raised now), optionally toggle start randomly while busy,
   // and check timing, vector order and final results against the response table f.
   task automatic run_sweep(input logic [15:0] f, input bit noise, input int accept_edges);
      int         edges, cycles, exp_cnt, first;
      bit         found;
      logic [3:0] seen[$];
      fn_tt = f;
      start = 1'b1;
      edges = 0;
      do begin
         tick();
         edges++;
      end while (!busy && edges < 4);
      start = 1'b0;
      check("accept_edges", edges, accept_edges);
      check("clear_tt", tt, 0);
      check("clear_err_cnt", err_cnt, 0);
      check("clear_mismatch", mismatch, 0);
      check("clear_err_idx", err_idx, 0);
      check("first_vec", vec, 0);
      seen.push_back(vec);
      cycles = 0;
      while (!done && cycles < SWEEP_CYC + 8) begin
         if (noise) start = 1'($urandom_range(0, 1));
         tick();
         cycles++;
         if (busy && vec != seen[$]) seen.push_back(vec);
      end
      start = 1'b0;
      check("done_latency", cycles, SWEEP_CYC);
      check("busy_at_done", busy, 0);
      check("vec_hold", vec, sweep_vec(15));
      check("vec_count", seen.size(), 16);
      for (int i = 0; i < 16 && i < seen.size(); i++) begin
         check("vec_order", seen[i], sweep_vec(i));
         if (GRAY && i > 0) check("gray_step", $countones(seen[i] ^ seen[i-1]), 1);
      end
      exp_cnt = $countones(f ^ EXPECTED);
      first = 0;
      found = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (!found && f[sweep_vec(i)] != EXPECTED[sweep_vec(i)]) begin
            first = sweep_vec(i);
            found = 1'b1;
         end
      end
      check("tt", tt, f);
      check("err_cnt", err_cnt, exp_cnt);
      check("mismatch", mismatch, exp_cnt != 0);
      check("err_idx", err_idx, first);
   endtask

   // After done: single-cycle pulse, no restart from start pulses seen while busy, results held.
   task automatic post_check(input logic [15:0] f);
      int dones;
      dones = 0;
      repeat (4) begin
         tick();
         if (done) dones++;
      end
      check("done_single", dones, 0);
      check("idle_busy", busy, 0);
      check("hold_tt", tt, f);
      check("hold_err_cnt", err_cnt, $countones(f ^ EXPECTED));
   endtask

   initial begin
      logic [15:0] f;
      int          k, dones;
      rst   = 1'b1;
      start = 1'b0;
      fn_tt = EXPECTED;
      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_vec", vec, 0);
      check("rst_tt", tt, 0);
      check("rst_mismatch", mismatch, 0);
      check("rst_err_cnt", err_cnt, 0);
      check("rst_err_idx", err_idx, 0);
      rst = 1'b0;
      tick();

      run_sweep(EXPECTED, 1'b0, 1);
      post_check(EXPECTED);
      run_sweep(16'h0000, 1'b1, 1);
      post_check(16'h0000);
      run_sweep(16'hFFFF, 1'b0, 1);
      post_check(16'hFFFF);
      run_sweep(EXPECTED, 1'b1, 1);
      post_check(EXPECTED);

      // start held through done: one IDLE cycle, then the next sweep is accepted
      f = 16'($urandom);
      run_sweep(f, 1'b0, 1);
      f = 16'($urandom);
      run_sweep(f, 1'b0, 2);
      post_check(f);

      for (int n = 0; n < 4; n++) begin
         f = 16'($urandom);
         run_sweep(f, n[0], 1);
         post_check(f);
      end

      // reset while vector 6 is driven
      fn_tt = 16'h0000;
      start = 1'b1;
      tick();
      start = 1'b0;
      k = 0;
      while (vec != 4'd6 && k < SWEEP_CYC + 8) begin
         tick();
         k++;
      end
      check("reach_vec6", vec, 6);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_vec", vec, 0);
      check("abort_tt", tt, 0);
      check("abort_mismatch", mismatch, 0);
      check("abort_err_cnt", err_cnt, 0);
      check("abort_err_idx", err_idx, 0);
      dones = 0;
      repeat (SWEEP_CYC) begin
         tick();
         if (done || busy) dones++;
      end
      check("abort_quiet", dones, 0);
      run_sweep(EXPECTED, 1'b0, 1);
      post_check(EXPECTED);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fn_sweep_ctrl.md
Name: fn_sweep_ctrl

Overview:
Sequencer for our 4-input combinational function blocks (a,b,c,d -> y).
- On a start pulse it drives all 16 input vectors into the function block, waits a settle time, samples y, and builds the 16-entry truth table.
- It checks each sample against an expected truth table and reports a pass/fail summary.
- It sits between the lab test harness and the function block under exercise.

Parameters:
- SETTLE, 1, cycles the vector is held before sampling; legal range 1..15.
- EXPECTED, 16'hB921, golden truth table; bit i is the y value for {a,b,c,d}=i, with a as MSB.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  sweep request; sampled only in IDLE
- dut_a  output  1  function input a (vector bit 3); registered
- dut_b  output  1  function input b (vector bit 2); registered
- dut_c  output  1  function input c (vector bit 1); registered
- dut_d  output  1  function input d (vector bit 0); registered
- dut_y  input  1  function output under test
- busy  output  1  sweep in progress
- done  output  1  single-cycle pulse when the sweep completes
- tt  output  16  captured truth table; bit i is the y sampled for vector i
- mismatch  output  1  sticky: at least one vector differed from EXPECTED
- err_cnt  output  5  number of mismatching vectors, 0..16
- err_idx  output  4  binary index of the first mismatching vector in sweep order; 0 if none

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, vector counter 0. Reset has priority over every other event, including mid-sweep; it aborts the sweep immediately with no done pulse.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - start=1 moves to DRIVE at that edge.
  - The same edge sets seq=0, clears tt, mismatch, err_cnt and err_idx, sets busy=1, and drives vector 0.
- DRIVE:
  - A settle counter loads SETTLE-1 on entry and decrements each cycle.
  - At count 0 the block moves to SAMPLE.
  - DRIVE therefore lasts SETTLE cycles.
- SAMPLE (one cycle; vector still held):
  - At the exiting edge, tt[vec] <= dut_y.
  - If dut_y != EXPECTED[vec]: err_cnt increments; mismatch <= 1; err_idx <= vec only if this is the first mismatch.
  - If seq==15, go to DONE.
  - Otherwise seq increments, the next vector is driven, and the block returns to DRIVE.
- Per-vector time is SETTLE+1 cycles. Full sweep time is 16*(SETTLE+1) cycles after the start edge.
- DONE (one cycle): done=1 and busy=0. dut_a..dut_d hold the last vector. The block returns to IDLE at the next edge; start during DONE is ignored.
- start while busy or in DONE has no effect; there is no queuing.
- Holding start high in IDLE starts back-to-back sweeps, with one IDLE cycle between them.
- tt, mismatch, err_cnt and err_idx hold their values from done until the next accepted start.
- Vector mapping: vec = seq (binary order), unless the optional feature is enabled. vec is decoded {dut_a,dut_b,dut_c,dut_d} = vec[3:0].
- Widths:
  - seq is 4 bits.
  - err_cnt is 5 bits and saturation is not needed, since the maximum is 16.
  - Equality compare is 1 bit.
- dut_y is treated as combinational from the dut_* registers. SETTLE covers the external propagation.

Optional Feature:
- Macro: SWEEP_GRAY_EN.
- Defined: vec = seq ^ (seq >> 1), giving sweep order 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8. Exactly one of dut_a..dut_d toggles per step. tt and EXPECTED stay indexed by the binary vector value; err_idx reports the binary vec.
- Not defined: binary order, 0..15.
- Timing is identical in both modes.

Test Plan:
1. Reset, then a start pulse with dut_y from a golden model of EXPECTED, SETTLE=1 -> done pulses 32 cycles after the start edge; tt=16'hB921, err_cnt=0, mismatch=0, err_idx=0.
2. dut_y tied 0, start -> tt=16'h0000, err_cnt=7, mismatch=1, err_idx=0.
3. dut_y tied 1, start -> tt=16'hFFFF, err_cnt=9, mismatch=1, err_idx=1.
4. Extra start pulses while busy, then start again after done -> only one done per accepted start; results clear at the second start edge, and the second sweep repeats test 1 values.
5. rst asserted for one cycle while vector 6 is driven -> next cycle all outputs 0 and busy=0 with no done pulse; a following start gives a clean tt=16'hB921.
6. SETTLE=3 with SWEEP_GRAY_EN defined -> done 64 cycles after start; the vector sequence matches the Gray order with a single-bit change per step; tt=16'hB921.
